pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register for the RISC-V core, replacing the fixed-field, busywait-only stage latches (ID/EX, EX/MEM, MEM/WB). It carries a generic data payload plus a control field through a valid/ready handshake with stall, flush (bubble insertion) and an optional two-entry skid buffer that breaks the combinational ready path. A saturating bubble counter supports pipeline performance measurement.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 22 ++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the flow-controlled pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Control value carried by a bubble; widened to CTRL_W at the use site.
  localparam int unsigned CTRL_BUBBLE = 0;

  // Bit positions of the control fields inside the CTRL_W control word.
  localparam int unsigned CTRL_MEM_R   = 0;
  localparam int unsigned CTRL_MEM_W   = 1;
  localparam int unsigned CTRL_WREG_EN = 2;
  localparam int unsigned CTRL_FUN3_LO = 3;
  localparam int unsigned CTRL_FUN3_HI = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for pipeline bubble statistics; never wraps.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !hold && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with stall, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(CTRL_BUBBLE);

  pipe_state_t       state_q, state_d;
  logic              valid_d;
  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              acc;
  logic              rel;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              rdy_q, rdy_d;

  // Registered readiness: no path from out_ready; stall and reset still gate it.
  assign in_ready = rdy_q && !stall && !reset;
`else
  assign in_ready = (!out_valid || out_ready) && !stall && !reset;
`endif

  assign acc = in_valid && in_ready;
  assign rel = out_valid && out_ready && !stall;

  // Next-state and datapath selection; flush outranks stall.
  always_comb begin
    state_d = state_q;
    valid_d = out_valid;
    data_d  = out_data;
    ctrl_d  = out_ctrl;
`ifdef PIPE_STAGE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      valid_d = 1'b0;
      ctrl_d  = BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl_d = BUBBLE;
`endif
    end else if (!stall) begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
          end
        end
        ONE: begin
`ifdef PIPE_STAGE_SKID_EN
          if (acc && !rel) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (acc) begin
`else
          if (acc) begin
`endif
            data_d = in_data;
            ctrl_d = in_ctrl;
          end else if (rel) begin
            state_d = EMPTY;
            valid_d = 1'b0;
            ctrl_d  = BUBBLE;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        TWO: begin
          // Skid entry is younger, so it only moves up once the output drains.
          if (rel) begin
            state_d     = ONE;
            data_d      = skid_data_q;
            ctrl_d      = skid_ctrl_q;
            skid_ctrl_d = BUBBLE;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          valid_d = 1'b0;
          ctrl_d  = BUBBLE;
        end
      endcase
    end
`ifdef PIPE_STAGE_SKID_EN
    rdy_d = (state_d != TWO);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= BUBBLE;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= BUBBLE;
      rdy_q       <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_ctrl  <= ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      rdy_q       <= rdy_d;
`endif
    end
  end

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_ready && !out_valid),
    .hold  (stall || flush),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: handshake table plus stall, flush, skid,
// saturation and asynchronous-reset sequences.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [15:0] bubble_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [7:0]  out_ctrl4;
  logic [3:0]  bubble_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_ctrl(out_ctrl4), .bubble_cnt(bubble_cnt4)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic st, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   64'(in_ready),   64'h0);
    check("rst_out_valid",  64'(out_valid),  64'h0);
    check("rst_out_data",   64'(out_data),   64'h0);
    check("rst_out_ctrl",   64'(out_ctrl),   64'h0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'h0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
  endtask

  initial begin
    vecs[0] = '{v:1'b1, d:32'h0000_00A5, c:8'h13, ordy:1'b1, fl:1'b0, ev:1'b1, ed:32'h0000_00A5, ec:8'h13};
    for (int i = 1; i <= 8; i++)
      vecs[i] = '{v:1'b1, d:32'h100 + 32'(i), c:8'(i), ordy:1'b1, fl:1'b0,
                  ev:1'b1, ed:32'h100 + 32'(i), ec:8'(i)};
    vecs[9]  = '{v:1'b0, d:32'h0,  c:8'h0,  ordy:1'b1, fl:1'b0, ev:1'b0, ed:32'h0,  ec:8'h0};
    vecs[10] = '{v:1'b1, d:32'h55, c:8'h1F, ordy:1'b1, fl:1'b1, ev:1'b0, ed:32'h0,  ec:8'h0};
    vecs[11] = '{v:1'b0, d:32'h0,  c:8'h0,  ordy:1'b1, fl:1'b0, ev:1'b0, ed:32'h0,  ec:8'h0};
    vecs[12] = '{v:1'b1, d:32'h77, c:8'h21, ordy:1'b1, fl:1'b0, ev:1'b1, ed:32'h77, ec:8'h21};
    vecs[13] = '{v:1'b1, d:32'h88, c:8'h22, ordy:1'b1, fl:1'b1, ev:1'b0, ed:32'h0,  ec:8'h0};

    #2;
    do_reset();

    // Table: first entry, 8 back-to-back entries, idle and flush cases.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].ordy, 1'b0, vecs[i].fl);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'h1);
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d_out_ctrl", i), 64'(out_ctrl), 64'(vecs[i].ec));
      if (vecs[i].ev)
        check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].ed));
    end

    // Stall holds an entry and freezes the bubble counter.
    do_reset();
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("stall_pre_bubble", 64'(bubble_cnt), 64'd3);
    drive(1'b1, 32'hDEAD_BEEF, 8'h33, 1'b0, 1'b0, 1'b0);
    tick();
    check("stall_load_valid", 64'(out_valid), 64'h1);
    drive(1'b1, 32'h99, 8'h66, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'h0);
      tick();
      check($sformatf("stall%0d_out_valid", i), 64'(out_valid), 64'h1);
      check($sformatf("stall%0d_out_data", i), 64'(out_data), 64'hDEAD_BEEF);
      check($sformatf("stall%0d_out_ctrl", i), 64'(out_ctrl), 64'h33);
      check($sformatf("stall%0d_bubble", i), 64'(bubble_cnt), 64'd3);
    end
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("unstall_release_valid", 64'(out_valid), 64'h0);
    check("unstall_release_ctrl", 64'(out_ctrl), 64'h0);

    // Flush wins over stall.
    drive(1'b1, 32'hABC, 8'h44, 1'b0, 1'b0, 1'b0);
    tick();
    check("fl_st_load_valid", 64'(out_valid), 64'h1);
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    tick();
    check("fl_st_out_valid", 64'(out_valid), 64'h0);
    check("fl_st_out_ctrl", 64'(out_ctrl), 64'h0);
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);

    // Bubble counter increments per idle ready cycle and saturates at width.
    do_reset();
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    check("sat_cnt4_mid", 64'(bubble_cnt4), 64'd10);
    check("sat_cnt16_mid", 64'(bubble_cnt), 64'd10);
    repeat (10) tick();
    check("sat_cnt4_end", 64'(bubble_cnt4), 64'd15);
    check("sat_cnt16_end", 64'(bubble_cnt), 64'd20);

`ifdef PIPE_STAGE_SKID_EN
    // Skid: two entries held while out_ready is low, drained in order.
    do_reset();
    drive(1'b1, 32'h11, 8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    check("skid_a_data", 64'(out_data), 64'h11);
    drive(1'b1, 32'h22, 8'h02, 1'b0, 1'b0, 1'b0);
    #1;
    check("skid_b_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("skid_two_in_ready", 64'(in_ready), 64'h0);
    check("skid_two_out_data", 64'(out_data), 64'h11);
    drive(1'b1, 32'h33, 8'h03, 1'b1, 1'b0, 1'b0);
    tick();
    check("skid_drain1_valid", 64'(out_valid), 64'h1);
    check("skid_drain1_data", 64'(out_data), 64'h22);
    check("skid_drain1_ctrl", 64'(out_ctrl), 64'h02);
    check("skid_drain1_in_ready", 64'(in_ready), 64'h1);
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("skid_drain2_valid", 64'(out_valid), 64'h0);
    check("skid_drain2_ctrl", 64'(out_ctrl), 64'h0);
`endif

    // Asynchronous reset in the middle of a cycle with entries held.
    do_reset();
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    check("arst_pre_bubble", 64'(bubble_cnt), 64'd2);
    drive(1'b1, 32'h44, 8'h0A, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 32'h45, 8'h0B, 1'b0, 1'b0, 1'b0);
    tick();
    check("arst_two_in_ready", 64'(in_ready), 64'h0);
`endif
    check("arst_pre_valid", 64'(out_valid), 64'h1);
    check("arst_pre_ctrl", 64'(out_ctrl), 64'h0A);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'h0);
    check("arst_out_ctrl", 64'(out_ctrl), 64'h0);
    check("arst_bubble", 64'(bubble_cnt), 64'h0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
